// File: rtl/fetch_buffer.sv
// fetch_buffer: small in-order instruction queue between fetch and decode.
// First-word-fall-through output, registered hold to fetch with SKID slots
// of headroom, synchronous flush on redirect, sticky overflow on dropped words.
module fetch_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SKID  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_ins,
    output logic                       hold,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_ins,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] HOLD_LVL = CW'(DEPTH - SKID);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             pop;
    logic             push;
    logic             drop;

    // Handshake decode; flush suppresses any incoming word entirely.
    always_comb begin
        out_valid = (count != '0);
        out_ins   = out_valid ? mem[rd_ptr] : '0;
        pop       = out_valid & out_ready;
        push      = in_valid & ~flush & ((count < FULL) | pop);
        drop      = in_valid & ~flush & (count == FULL) & ~pop;
    end

    // Post-update occupancy, used for both count and hold.
    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push & ~pop)
            count_next = count + 1'b1;
        else if (pop & ~push)
            count_next = count - 1'b1;
    end

    // Pointer, count, hold and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            // Raised while SKID free slots remain so in-flight words still fit.
            hold  <= (count_next >= HOLD_LVL);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage array; contents are never reset, only gated by count.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= in_ins;
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (WIDTH=32, DEPTH=4, SKID=2).
module tb_fetch_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_ins;
    logic        hold;
    logic        out_valid;
    logic [31:0] out_ins;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    fetch_buffer #(.WIDTH(32), .DEPTH(4), .SKID(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ins(in_ins), .hold(hold),
        .out_valid(out_valid), .out_ins(out_ins), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] c, input logic h,
                             input logic v, input logic [31:0] ins);
        chk({tag, " count"}, {29'd0, count}, {29'd0, c});
        chk({tag, " hold"}, {31'd0, hold}, {31'd0, h});
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, " out_ins"}, out_ins, ins);
    endtask

    initial begin
        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1; flush = 0; in_valid = 1; in_ins = 32'hdead; out_ready = 0;
        step(); step();
        rst = 0; in_valid = 0;
        chk_state("reset", 3'd0, 1'b0, 1'b0, 32'h0);
        chk("reset overflow", {31'd0, overflow}, 32'd0);

        // Fill with decode stalled; hold rises when count reaches 2.
        in_valid = 1; in_ins = 32'h11; step();
        chk_state("fill1", 3'd1, 1'b0, 1'b1, 32'h11);
        in_ins = 32'h22; step();
        chk_state("fill2", 3'd2, 1'b1, 1'b1, 32'h11);
        in_ins = 32'h33; step();
        chk_state("fill3", 3'd3, 1'b1, 1'b1, 32'h11);
        in_ins = 32'h44; step();
        chk_state("fill4", 3'd4, 1'b1, 1'b1, 32'h11);
        chk("fill4 overflow", {31'd0, overflow}, 32'd0);

        // Full and stalled: 0x55 is dropped.
        in_ins = 32'h55; step();
        chk_state("drop", 3'd4, 1'b1, 1'b1, 32'h11);
        chk("drop overflow", {31'd0, overflow}, 32'd1);

        // Full with simultaneous pop: push of 0x66 accepted.
        in_ins = 32'h66; out_ready = 1; step();
        chk_state("fullpp", 3'd4, 1'b1, 1'b1, 32'h22);
        chk("fullpp overflow", {31'd0, overflow}, 32'd1);

        // Drain: 0x22, 0x33, 0x44, 0x66 in order (0x55 never appears).
        in_valid = 0;
        step(); chk_state("drain1", 3'd3, 1'b1, 1'b1, 32'h33);
        step(); chk_state("drain2", 3'd2, 1'b1, 1'b1, 32'h44);
        step(); chk_state("drain3", 3'd1, 1'b0, 1'b1, 32'h66);
        step(); chk_state("drain4", 3'd0, 1'b0, 1'b0, 32'h0);

        // Flush at count=3 with a simultaneous input word and pop.
        out_ready = 0; in_valid = 1;
        in_ins = 32'ha1; step();
        in_ins = 32'ha2; step();
        in_ins = 32'ha3; step();
        chk_state("preflush", 3'd3, 1'b1, 1'b1, 32'ha1);
        flush = 1; in_ins = 32'h77; out_ready = 1; step();
        chk_state("flush", 3'd0, 1'b0, 1'b0, 32'h0);
        chk("flush overflow", {31'd0, overflow}, 32'd1);
        flush = 0; in_valid = 0; step();
        chk_state("postflush", 3'd0, 1'b0, 1'b0, 32'h0);

        // Streaming through several pointer wraps, one cycle latency.
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_ins = 32'h100 + i; step();
            chk_state($sformatf("stream%0d", i), 3'd1, 1'b0, 1'b1, 32'h100 + i);
        end
        in_valid = 0; step();
        chk_state("streamend", 3'd0, 1'b0, 1'b0, 32'h0);

        // Only reset clears the sticky overflow.
        rst = 1; step(); rst = 0;
        chk("rst2 overflow", {31'd0, overflow}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
